// File: rtl/uart_pkt_pkg.sv
// Shared types and defaults for the framed UART packet reader.
package uart_pkt_pkg;

  typedef enum logic [2:0] {IDLE, PAYLOAD, CHECK, DONE, VETO} state_t;

  localparam logic [7:0] HEADER_DEFAULT  = 8'h55;
  localparam int         CLK_DIV_DEFAULT = 1736;

endpackage

// File: rtl/uart_byte_rx.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling every CLK_DIV cycles.
// byte_valid pulses the cycle after a stop-bit sample of 1; framing errors are dropped.
module uart_byte_rx #(
  parameter int CLK_DIV = 1736
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_in,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  rx_state_t     st_q;
  logic [2:0]    sync_q;  // [1] is the synchronised line, [2] its previous value
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          rx;

  assign rx = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= R_IDLE;
      sync_q     <= 3'b111;
      cnt_q      <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      sync_q     <= {sync_q[1:0], uart_in};
      byte_valid <= 1'b0;
      case (st_q)
        R_IDLE: if (sync_q[2] && !rx) begin
          st_q  <= R_START;
          cnt_q <= '0;
        end
        R_START: if (cnt_q == HALF) begin
          cnt_q <= '0;
          bit_q <= '0;
          st_q  <= rx ? R_IDLE : R_DATA;  // a glitch that is high again at mid-bit is ignored
        end else cnt_q <= cnt_q + 1'b1;
        R_DATA: if (cnt_q == FULL) begin
          cnt_q <= '0;
          sh_q  <= {rx, sh_q[7:1]};
          bit_q <= bit_q + 1'b1;
          if (bit_q == 3'd7) st_q <= R_STOP;
        end else cnt_q <= cnt_q + 1'b1;
        R_STOP: if (cnt_q == FULL) begin
          cnt_q      <= '0;
          st_q       <= R_IDLE;
          byte_valid <= rx;
          byte_data  <= sh_q;
        end else cnt_q <= cnt_q + 1'b1;
        default: st_q <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_packet_reader.sv
// Framed packet receiver: HEADER byte, N_BYTE payload bytes, optional XOR checksum
// byte when UART_PKT_CHECKSUM_EN is defined; timeout and header errors open a veto window.
module uart_packet_reader
  import uart_pkt_pkg::*;
#(
  parameter int         N_BYTE      = 5,
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  parameter int         CLK_DIV     = CLK_DIV_DEFAULT,
  parameter int         TIMEOUT_CYC = 200000,
  parameter int         VETO_CYC    = 200000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_in,
  output logic                valid,
  output logic [N_BYTE*8-1:0] q,
  output logic                err_header,
  output logic                err_timeout,
  output logic                err_checksum,
  output logic                busy
);

  localparam int W  = N_BYTE * 8;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int VW = $clog2(VETO_CYC + 1);
  localparam int IW = $clog2(N_BYTE + 1);

  localparam logic [TW-1:0] T_LIM    = TW'(TIMEOUT_CYC - 1);
  localparam logic [VW-1:0] V_LIM    = VW'(VETO_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_BYTE - 1);

  logic          rx_valid;
  logic [7:0]    rx_data;
  state_t        state_q;
  logic [TW-1:0] timer_q, timer_d;
  logic [VW-1:0] veto_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  shadow_q;
  logic          pl_done;

  uart_byte_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .uart_in    (uart_in),
    .byte_valid (rx_valid),
    .byte_data  (rx_data)
  );

  assign timer_d = timer_q + 1'b1;
  assign busy    = (state_q != IDLE);

`ifdef UART_PKT_CHECKSUM_EN
  localparam state_t AFTER_PL = CHECK;
  logic [7:0] csum_q;
  logic       err_chk_q;
  assign err_checksum = err_chk_q;
  assign pl_done      = 1'b0;
`else
  localparam state_t AFTER_PL = DONE;
  assign err_checksum = 1'b0;
  assign pl_done      = rx_valid && (idx_q == LAST_IDX);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      veto_q      <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      q           <= '0;
      valid       <= 1'b0;
      err_header  <= 1'b0;
      err_timeout <= 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
      csum_q      <= '0;
      err_chk_q   <= 1'b0;
`endif
    end else begin
      valid       <= 1'b0;
      err_header  <= 1'b0;
      err_timeout <= 1'b0;
`ifdef UART_PKT_CHECKSUM_EN
      err_chk_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: if (rx_valid) begin
          if (rx_data == HEADER) begin
            state_q <= PAYLOAD;
            idx_q   <= '0;
            timer_q <= '0;
`ifdef UART_PKT_CHECKSUM_EN
            csum_q  <= '0;
`endif
          end else begin
            state_q    <= VETO;
            veto_q     <= '0;
            err_header <= 1'b1;
          end
        end
        PAYLOAD: begin
          timer_q <= timer_d;
          if (rx_valid) begin
            for (int i = 0; i < N_BYTE; i++)
              if (idx_q == IW'(i)) shadow_q[i*8 +: 8] <= rx_data;
            idx_q <= idx_q + 1'b1;
`ifdef UART_PKT_CHECKSUM_EN
            csum_q <= csum_q ^ rx_data;
`endif
            if (idx_q == LAST_IDX) state_q <= AFTER_PL;
          end
          // A completing byte in the limit cycle beats the timeout.
          if (timer_d == T_LIM && !pl_done) begin
            state_q     <= VETO;
            veto_q      <= '0;
            err_timeout <= 1'b1;
          end
        end
`ifdef UART_PKT_CHECKSUM_EN
        CHECK: begin
          timer_q <= timer_d;
          if (rx_valid) begin
            if (rx_data == csum_q) state_q <= DONE;
            else begin
              state_q   <= IDLE;
              err_chk_q <= 1'b1;
            end
          end else if (timer_d == T_LIM) begin
            state_q     <= VETO;
            veto_q      <= '0;
            err_timeout <= 1'b1;
          end
        end
`endif
        DONE: begin
          q       <= shadow_q;
          valid   <= 1'b1;
          state_q <= IDLE;
        end
        VETO: begin
          if (veto_q == V_LIM) state_q <= IDLE;
          else veto_q <= veto_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_packet_reader.sv
// Randomised scoreboard bench for uart_packet_reader (N_BYTE=5, CLK_DIV=16, TIMEOUT 2000, VETO 500).
module tb_uart_packet_reader;

  localparam int N  = 5;
  localparam int CD = 16;
  localparam int TO = 2000;
  localparam int VC = 500;
  localparam int W  = N * 8;
  localparam logic [7:0] HDR = 8'h55;
`ifdef UART_PKT_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         uart_in = 1'b1;
  logic         valid, err_header, err_timeout, err_checksum, busy;
  logic [W-1:0] q;

  uart_packet_reader #(
    .N_BYTE(N), .HEADER(HDR), .CLK_DIV(CD), .TIMEOUT_CYC(TO), .VETO_CYC(VC)
  ) u_dut (
    .clk(clk), .rst(rst), .uart_in(uart_in), .valid(valid), .q(q),
    .err_header(err_header), .err_timeout(err_timeout),
    .err_checksum(err_checksum), .busy(busy)
  );

  always #5 clk = ~clk;

  // kind: 0 valid, 1 header error, 2 timeout, 3 checksum error
  typedef struct {int kind; logic [W-1:0] q; bit timed;} exp_t;
  typedef logic [7:0] bq_t[$];
  typedef bit oq_t[$];

  exp_t         exp_q[$];
  int           checks = 0, fails = 0, cyc = 0;
  logic [W-1:0] last_q = '0;
  bit           arm_hdr = 1'b0;
  int           hdr_cyc = 0, last_bv = 0;
  int           mkind, nout, veto_left = 0, veto_bad = 0;
  bit           veto_end = 1'b0;
  exp_t         me;

  task automatic chk(input string nm, input longint act, input longint ex);
    checks++;
    if (act !== ex) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  // Reference: apply the packet rules to the bytes that survive framing.
  function automatic exp_t model(input bq_t bs, input oq_t ok);
    bq_t          rx;
    exp_t         e;
    logic [W-1:0] p;
    logic [7:0]   x;
    foreach (bs[i]) if (ok[i]) rx.push_back(bs[i]);
    e.q = last_q; e.timed = 1'b0; p = '0; x = '0;
    if (rx[0] != HDR) e.kind = 1;
    else if (rx.size() < 1 + N + CK) begin e.kind = 2; e.timed = 1'b1; end
    else begin
      for (int i = 0; i < N; i++) begin p[i*8 +: 8] = rx[1+i]; x ^= rx[1+i]; end
      if (CK == 1 && rx[1+N] != x) e.kind = 3;
      else begin e.kind = 0; e.q = p; last_q = p; end
    end
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard whenever the DUT reports anything.
  always @(negedge clk) begin
    if (!rst) begin
      if (u_dut.rx_valid) begin
        last_bv = cyc;
        if (arm_hdr) begin hdr_cyc = cyc; arm_hdr = 1'b0; end
      end
      nout = int'(valid) + int'(err_header) + int'(err_timeout) + int'(err_checksum);
      if (nout > 1) chk("one_output_at_a_time", nout, 1);
      if (nout > 0) begin
        mkind = valid ? 0 : err_header ? 1 : err_timeout ? 2 : 3;
        if (exp_q.size() == 0) chk("spurious_output_kind", mkind, -1);
        else begin
          me = exp_q.pop_front();
          chk("output_kind", mkind, me.kind);
          chk("q_value", q, me.q);
          if (mkind == 0) chk("valid_latency", cyc - last_bv, 2);
          if (mkind == 1 || mkind == 3) chk("err_latency", cyc - last_bv, 1);
          if (me.timed && mkind == 2) chk("timeout_cycle", cyc - hdr_cyc, TO);
          if (mkind == 3) chk("no_veto_after_checksum", busy, 0);
        end
        if (err_header || err_timeout) begin veto_left = VC; veto_bad = 0; end
      end
      if (veto_left > 0) begin
        if (!busy) veto_bad++;
        veto_left--;
        if (veto_left == 0) veto_end = 1'b1;
      end else if (veto_end) begin
        chk("veto_busy_window", veto_bad * 2 + int'(busy), 0);
        veto_end = 1'b0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit ok);
    uart_in = 1'b0;
    repeat (CD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin uart_in = b[i]; repeat (CD) @(negedge clk); end
    uart_in = ok;
    repeat (CD) @(negedge clk);
    uart_in = 1'b1;
    if (!ok) repeat (CD) @(negedge clk);
  endtask

  task automatic run_burst(input bq_t bs, input oq_t ok);
    exp_t e;
    int   t;
    e = model(bs, ok);
    exp_q.push_back(e);
    arm_hdr = 1'b1;
    foreach (bs[i]) send_byte(bs[i], ok[i]);
    t = 0;
    while (exp_q.size() != 0 && t < TO + 1000) begin @(negedge clk); t++; end
    chk("response_seen", exp_q.size(), 0);
    exp_q.delete();
    repeat ((e.kind == 1 || e.kind == 2) ? VC + 20 : 20) @(negedge clk);
  endtask

  task automatic good_pkt(input logic [7:0] b0, output bq_t bs, output oq_t ok);
    logic [7:0] x;
    x = '0;
    bs = {HDR}; ok = {1'b1};
    for (int i = 0; i < N; i++) begin
      bs.push_back(b0 + 8'(i)); ok.push_back(1'b1); x ^= b0 + 8'(i);
    end
    if (CK == 1) begin bs.push_back(x); ok.push_back(1'b1); end
  endtask

  initial begin
    bq_t        bs;
    oq_t        ok;
    int         kind;
    logic [7:0] b, x;

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_q", q, 0);
    chk("reset_valid", valid, 0);
    chk("reset_errs", {err_header, err_timeout, err_checksum}, 0);
    chk("reset_busy", busy, 0);

    // Good packet 55 01..05
    good_pkt(8'h01, bs, ok);
    run_burst(bs, ok);
    chk("good_q_literal", q, 40'h0504030201);

    // Bad header, trailing bytes land inside the veto; then a good packet
    bs = {8'hAA, HDR, 8'h01}; ok = {1'b1, 1'b1, 1'b1};
    run_burst(bs, ok);
    good_pkt(8'h01, bs, ok);
    run_burst(bs, ok);

    // Header plus 3 bytes then silence
    bs = {HDR, 8'h01, 8'h02, 8'h03}; ok = {1'b1, 1'b1, 1'b1, 1'b1};
    run_burst(bs, ok);

    if (CK == 1) begin
      bs = {HDR, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h01}; ok = {1, 1, 1, 1, 1, 1, 1};
      run_burst(bs, ok);
      bs = {HDR, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00}; ok = {1, 1, 1, 1, 1, 1, 1};
      run_burst(bs, ok);
      chk("q_kept_after_checksum_err", q, 40'h0504030201);
    end

    // Reset after the third payload byte aborts silently and clears q
    send_byte(HDR, 1'b1);
    for (int i = 0; i < 3; i++) send_byte(8'h11 + 8'(i), 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_q = '0;
    @(negedge clk);
    chk("midpkt_reset_q", q, 0);
    chk("midpkt_reset_busy", busy, 0);
    good_pkt(8'h11, bs, ok);
    run_burst(bs, ok);
    chk("after_reset_q_literal", q, 40'h1514131211);

    // Framing error on payload byte 2
    bs = {HDR, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05}; ok = {1, 1, 0, 1, 1, 1};
    if (CK == 1) begin bs.push_back(8'h01); ok.push_back(1'b1); end
    run_burst(bs, ok);
    chk("q_kept_after_framing", q, 40'h1514131211);

    // Randomised bursts
    for (int n = 0; n < 14; n++) begin
      kind = $urandom_range(0, 3 + CK);
      bs = {}; ok = {};
      if (kind == 1) begin
        do b = 8'($urandom); while (b == HDR);
        bs.push_back(b); ok.push_back(1'b1);
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
          bs.push_back(8'($urandom)); ok.push_back(1'b1);
        end
      end else if (kind == 2) begin
        bs.push_back(HDR); ok.push_back(1'b1);
        for (int i = 0; i < int'($urandom_range(0, N - 1)); i++) begin
          bs.push_back(8'($urandom)); ok.push_back(1'b1);
        end
      end else begin
        x = '0;
        bs.push_back(HDR); ok.push_back(1'b1);
        for (int i = 0; i < N; i++) begin
          b = 8'($urandom); x ^= b;
          bs.push_back(b); ok.push_back(1'b1);
        end
        if (kind == 3) ok[1 + $urandom_range(0, N - 1)] = 1'b0;
        if (CK == 1) begin
          if (kind == 4) x ^= 8'($urandom_range(1, 255));
          bs.push_back(x); ok.push_back(1'b1);
        end
      end
      run_burst(bs, ok);
    end

    repeat (50) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
